wishbone_multi_device_decoder: RTL and testbench



---
 rtl/wishbone_multi_device_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_wishbone_multi_device_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_multi_device_decoder.sv
//==============================================================================
// wishbone_multi_device_decoder: one Wishbone controller to four devices,
// with address decode, outstanding tracking and timeout abort.  Rev 1.0
//==============================================================================
`default_nettype none

module wishbone_multi_device_decoder #(
  parameter logic [3:0] DEVICE_MASK     = 4'b1111,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         TIMEOUT_CYCLES  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        controller_wb_cyc_o,
  input  logic        controller_wb_stb_o,
  input  logic        controller_wb_we_o,
  input  logic [3:0]  controller_wb_sel_o,
  input  logic [31:0] controller_wb_data_o,
  input  logic [23:0] controller_wb_adr_o,
  output logic        controller_wb_ack_i,
  output logic        controller_wb_stall_i,
  output logic        controller_wb_error_i,
  output logic [31:0] controller_wb_data_i,
  output logic        device0_cyc_i,
  output logic        device0_stb_i,
  output logic        device1_cyc_i,
  output logic        device1_stb_i,
  output logic        device2_cyc_i,
  output logic        device2_stb_i,
  output logic        device3_cyc_i,
  output logic        device3_stb_i,
  output logic        device_we_i,
  output logic [3:0]  device_sel_i,
  output logic [31:0] device_data_i,
  output logic [23:0] device_adr_i,
  input  logic        device0_ack_o,
  input  logic        device0_stall_o,
  input  logic        device0_error_o,
  input  logic [31:0] device0_data_o,
  input  logic        device1_ack_o,
  input  logic        device1_stall_o,
  input  logic        device1_error_o,
  input  logic [31:0] device1_data_o,
  input  logic        device2_ack_o,
  input  logic        device2_stall_o,
  input  logic        device2_error_o,
  input  logic [31:0] device2_data_o,
  input  logic        device3_ack_o,
  input  logic        device3_stall_o,
  input  logic        device3_error_o,
  input  logic [31:0] device3_data_o,
  output logic [1:0]  probe_state,
  output logic [1:0]  probe_currentDevice
);

  localparam logic [3:0] c_max_out = 4'(MAX_OUTSTANDING);
  localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [1:0]  r_current, w_current_next;
  logic [3:0]  r_outstanding, w_outstanding_next;
  logic [7:0]  r_timer, w_timer_next;
  logic        r_err, w_err_next;

  logic [3:0]  w_dev_ack, w_dev_stall, w_dev_err;
  logic [31:0] w_dev_data [4];
  logic [1:0]  w_target, w_active;
  logic        w_mapped, w_req, w_forward, w_block, w_unmapped;
  logic        w_rsp, w_accept, w_dec;
  logic [3:0]  w_cyc, w_stb;
  logic [3:0]  w_count;
  logic        w_ack, w_stall, w_dev_error;
  logic [31:0] w_data;

  assign w_dev_ack   = {device3_ack_o, device2_ack_o, device1_ack_o, device0_ack_o};
  assign w_dev_stall = {device3_stall_o, device2_stall_o, device1_stall_o, device0_stall_o};
  assign w_dev_err   = {device3_error_o, device2_error_o, device1_error_o, device0_error_o};
  assign w_dev_data[0] = device0_data_o;
  assign w_dev_data[1] = device1_data_o;
  assign w_dev_data[2] = device2_data_o;
  assign w_dev_data[3] = device3_data_o;

  assign w_target = controller_wb_adr_o[23:22];
  assign w_mapped = DEVICE_MASK[w_target];
  assign w_req    = controller_wb_cyc_o & controller_wb_stb_o;

  // Routing: pick the active device, decide stall blocking, mux responses.
  always_comb begin
    w_active    = r_current;
    w_forward   = 1'b0;
    w_block     = 1'b0;
    w_unmapped  = 1'b0;
    w_cyc       = 4'b0;
    w_stb       = 4'b0;
    w_stall     = 1'b0;
    w_ack       = 1'b0;
    w_dev_error = 1'b0;
    w_data      = 32'b0;
    case (r_state)
      S_IDLE: begin
        w_active   = w_target;
        w_forward  = controller_wb_cyc_o & w_mapped;
        w_unmapped = w_req & ~w_mapped;
      end
      S_BUSY: begin
        w_forward  = controller_wb_cyc_o;
        w_unmapped = w_req & ~w_mapped & (r_outstanding == 4'd0);
        if (w_req && w_mapped && (w_target != r_current) && (r_outstanding == 4'd0))
          w_active = w_target;
        // A response arriving this cycle frees a slot for the new strobe.
        w_block = controller_wb_stb_o &
                  (((r_outstanding == c_max_out) & ~(w_dev_ack[w_active] | w_dev_err[w_active])) |
                   ((r_outstanding != 4'd0) & ((w_target != r_current) | ~w_mapped)));
      end
      S_TIMEOUT: w_stall = 1'b1;
      default: ;
    endcase
    if (!wb_rst_i) begin
      w_forward  = 1'b0;
      w_unmapped = 1'b0;
      w_block    = 1'b0;
      w_stall    = 1'b0;
    end
    if (w_forward) begin
      w_cyc[w_active] = 1'b1;
      w_stb[w_active] = controller_wb_stb_o & ~w_block & ~w_unmapped;
      w_stall         = w_block | (~w_unmapped & w_dev_stall[w_active]);
      w_ack           = w_dev_ack[w_active];
      w_dev_error     = w_dev_err[w_active];
      w_data          = w_dev_data[w_active];
    end
  end

  assign w_rsp    = w_forward & (w_dev_ack[w_active] | w_dev_err[w_active]);
  assign w_accept = w_forward & controller_wb_stb_o & ~w_stall & ~w_unmapped;
  assign w_dec    = w_rsp & ((r_outstanding != 4'd0) | w_accept);
  assign w_count  = r_outstanding + 4'(w_accept) - 4'(w_dec);

  always_comb begin
    w_state_next       = r_state;
    w_current_next     = r_current;
    w_outstanding_next = r_outstanding;
    w_timer_next       = r_timer;
    w_err_next         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_unmapped) begin
          w_err_next = 1'b1;
        end else if (w_req && w_mapped) begin
          w_state_next       = S_BUSY;
          w_current_next     = w_target;
          w_outstanding_next = w_count;
          w_timer_next       = 8'd0;
        end
      end
      S_BUSY: begin
        if (!controller_wb_cyc_o) begin
          w_state_next       = S_IDLE;
          w_outstanding_next = 4'd0;
          w_timer_next       = 8'd0;
        end else begin
          w_current_next     = w_active;
          w_outstanding_next = w_count;
          w_err_next         = w_unmapped;
          if (w_accept || w_rsp || (r_outstanding == 4'd0)) begin
            w_timer_next = 8'd0;
          end else if (r_timer + 8'd1 == c_timeout) begin
            w_state_next       = S_TIMEOUT;
            w_outstanding_next = 4'd0;
            w_timer_next       = 8'd0;
            w_err_next         = 1'b1;
          end else begin
            w_timer_next = r_timer + 8'd1;
          end
        end
      end
      S_TIMEOUT: begin
        if (!controller_wb_cyc_o) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state       <= S_IDLE;
      r_current     <= 2'd0;
      r_outstanding <= 4'd0;
      r_timer       <= 8'd0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_current     <= w_current_next;
      r_outstanding <= w_outstanding_next;
      r_timer       <= w_timer_next;
      r_err         <= w_err_next;
    end
  end

  assign controller_wb_ack_i   = w_ack;
  assign controller_wb_stall_i = w_stall;
  assign controller_wb_error_i = r_err | w_dev_error;
  assign controller_wb_data_i  = w_data;

  assign {device3_cyc_i, device2_cyc_i, device1_cyc_i, device0_cyc_i} = w_cyc;
  assign {device3_stb_i, device2_stb_i, device1_stb_i, device0_stb_i} = w_stb;

  assign device_we_i   = controller_wb_we_o;
  assign device_sel_i  = controller_wb_sel_o;
  assign device_data_i = controller_wb_data_o;
  assign device_adr_i  = controller_wb_adr_o;

  assign probe_state         = r_state;
  assign probe_currentDevice = r_current;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_multi_device_decoder.sv
//==============================================================================
// tb_wishbone_multi_device_decoder: directed checks of decode, outstanding
// limit, retarget, timeout and asynchronous reset.  Rev 1.0
//==============================================================================
`default_nettype none

module tb_wishbone_multi_device_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [23:0] adr;
  logic        ack, stall, err;
  logic [31:0] rdata;
  logic        c0, c1, c2, c3, s0, s1, s2, s3;
  logic        dwe;
  logic [3:0]  dsel;
  logic [31:0] ddata;
  logic [23:0] dadr;
  logic [3:0]  d_ack, d_stall, d_err;
  logic [31:0] d_data [4];
  logic [1:0]  pstate, pcur;

  wire [3:0] cyc_v = {c3, c2, c1, c0};
  wire [3:0] stb_v = {s3, s2, s1, s0};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wishbone_multi_device_decoder #(
    .DEVICE_MASK(4'b0111), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .controller_wb_cyc_o(cyc), .controller_wb_stb_o(stb), .controller_wb_we_o(we),
    .controller_wb_sel_o(sel), .controller_wb_data_o(wdata), .controller_wb_adr_o(adr),
    .controller_wb_ack_i(ack), .controller_wb_stall_i(stall),
    .controller_wb_error_i(err), .controller_wb_data_i(rdata),
    .device0_cyc_i(c0), .device0_stb_i(s0), .device1_cyc_i(c1), .device1_stb_i(s1),
    .device2_cyc_i(c2), .device2_stb_i(s2), .device3_cyc_i(c3), .device3_stb_i(s3),
    .device_we_i(dwe), .device_sel_i(dsel), .device_data_i(ddata), .device_adr_i(dadr),
    .device0_ack_o(d_ack[0]), .device0_stall_o(d_stall[0]), .device0_error_o(d_err[0]), .device0_data_o(d_data[0]),
    .device1_ack_o(d_ack[1]), .device1_stall_o(d_stall[1]), .device1_error_o(d_err[1]), .device1_data_o(d_data[1]),
    .device2_ack_o(d_ack[2]), .device2_stall_o(d_stall[2]), .device2_error_o(d_err[2]), .device2_data_o(d_data[2]),
    .device3_ack_o(d_ack[3]), .device3_stall_o(d_stall[3]), .device3_error_o(d_err[3]), .device3_data_o(d_data[3]),
    .probe_state(pstate), .probe_currentDevice(pcur)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hA; wdata = 32'h1234_5678; adr = 24'h123456;
    d_ack = 4'b0; d_stall = 4'b0; d_err = 4'b0;
    for (int i = 0; i < 4; i++) d_data[i] = 32'h1000_0000 * (i + 1);
    #2;
    check("rst_state", 32'(pstate), 32'd0);
    check("rst_cur", 32'(pcur), 32'd0);
    check("rst_cyc", 32'(cyc_v), 32'd0);
    check("rst_stb", 32'(stb_v), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_pass_adr", 32'(dadr), 32'h123456);
    check("rst_pass_wd", ddata, 32'h1234_5678);
    check("rst_pass_sel", 32'(dsel), 32'hA);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Read from device1, acked two cycles after the strobe
    adr = 24'h400010; cyc = 1'b1; stb = 1'b1; #1;
    check("rd_cyc", 32'(cyc_v), 32'b0010);
    check("rd_stb", 32'(stb_v), 32'b0010);
    check("rd_stall", 32'(stall), 32'd0);
    tick(); stb = 1'b0; #1;
    check("rd_state", 32'(pstate), 32'd1);
    check("rd_cur", 32'(pcur), 32'd1);
    check("rd_stb_off", 32'(stb_v), 32'd0);
    tick();
    d_ack[1] = 1'b1; d_data[1] = 32'hDEADBEEF; #1;
    check("rd_ack", 32'(ack), 32'd1);
    check("rd_data", rdata, 32'hDEADBEEF);
    tick(); d_ack[1] = 1'b0; cyc = 1'b0; #1;
    check("rd_cyc_drop", 32'(cyc_v), 32'd0);
    tick();
    check("rd_idle", 32'(pstate), 32'd0);

    // Unmapped device3
    adr = 24'hC00000; cyc = 1'b1; stb = 1'b1; #1;
    check("um_stb", 32'(stb_v), 32'd0);
    check("um_cyc", 32'(cyc_v), 32'd0);
    check("um_stall", 32'(stall), 32'd0);
    check("um_err_early", 32'(err), 32'd0);
    tick(); cyc = 1'b0; stb = 1'b0; #1;
    check("um_err", 32'(err), 32'd1);
    check("um_state", 32'(pstate), 32'd0);
    tick();
    check("um_err_end", 32'(err), 32'd0);

    // Outstanding limit on device0
    adr = 24'h000000; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ol_accept_stall", 32'(stall), 32'd0);
      tick();
    end
    check("ol_full_stall", 32'(stall), 32'd1);
    check("ol_full_stb", 32'(stb_v), 32'd0);
    tick();
    check("ol_full_stall2", 32'(stall), 32'd1);
    d_ack[0] = 1'b1; #1;
    check("ol_ack_stall", 32'(stall), 32'd0);
    check("ol_ack_stb", 32'(stb_v), 32'b0001);
    check("ol_ack", 32'(ack), 32'd1);
    tick(); d_ack[0] = 1'b0; #1;
    check("ol_still_full", 32'(stall), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    tick();
    check("ol_idle", 32'(pstate), 32'd0);

    // Retarget from device0 to device2
    adr = 24'h000000; cyc = 1'b1; stb = 1'b1;
    tick();
    adr = 24'h800000; #1;
    check("sw_stall", 32'(stall), 32'd1);
    check("sw_stb", 32'(stb_v), 32'd0);
    tick();
    check("sw_stall2", 32'(stall), 32'd1);
    d_ack[0] = 1'b1; #1;
    check("sw_stall_ack", 32'(stall), 32'd1);
    check("sw_ack", 32'(ack), 32'd1);
    tick(); d_ack[0] = 1'b0; #1;
    check("sw_stb2", 32'(stb_v), 32'b0100);
    check("sw_cyc2", 32'(cyc_v), 32'b0100);
    check("sw_stall_off", 32'(stall), 32'd0);
    tick(); stb = 1'b0; #1;
    check("sw_cur", 32'(pcur), 32'd2);
    cyc = 1'b0;
    tick();
    check("sw_idle", 32'(pstate), 32'd0);

    // Timeout: strobe accepted, never answered
    adr = 24'h000000; cyc = 1'b1; stb = 1'b1;
    tick(); stb = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_wait_err", 32'(err), 32'd0);
      check("to_wait_state", 32'(pstate), 32'd1);
    end
    tick();
    check("to_err", 32'(err), 32'd1);
    check("to_state", 32'(pstate), 32'd2);
    check("to_cyc", 32'(cyc_v), 32'd0);
    check("to_stall", 32'(stall), 32'd1);
    tick();
    check("to_err_end", 32'(err), 32'd0);
    check("to_stall_hold", 32'(stall), 32'd1);
    check("to_state_hold", 32'(pstate), 32'd2);
    cyc = 1'b0;
    tick();
    check("to_idle", 32'(pstate), 32'd0);
    check("to_stall_off", 32'(stall), 32'd0);

    // Asynchronous reset while BUSY
    adr = 24'h400000; cyc = 1'b1; stb = 1'b1; d_stall[1] = 1'b1;
    tick();
    d_ack[1] = 1'b1; #1;
    check("ar_state", 32'(pstate), 32'd1);
    check("ar_stall", 32'(stall), 32'd1);
    check("ar_ack", 32'(ack), 32'd1);
    check("ar_cyc", 32'(cyc_v), 32'b0010);
    #1 rst_n = 1'b0; #1;
    check("ar_rst_cyc", 32'(cyc_v), 32'd0);
    check("ar_rst_stb", 32'(stb_v), 32'd0);
    check("ar_rst_stall", 32'(stall), 32'd0);
    check("ar_rst_ack", 32'(ack), 32'd0);
    check("ar_rst_err", 32'(err), 32'd0);
    check("ar_rst_state", 32'(pstate), 32'd0);
    check("ar_rst_cur", 32'(pcur), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
